// File: rtl/btn_event_scheduler_pkg.sv
// Shared button definitions for the input front-end and for consumers decoding evt_id.
package btn_pkg;

  localparam int NUM_BTN = 4;

  typedef logic [1:0] btn_id_t;

  localparam btn_id_t BTN_UP    = 2'd0;
  localparam btn_id_t BTN_DOWN  = 2'd1;
  localparam btn_id_t BTN_LEFT  = 2'd2;
  localparam btn_id_t BTN_RIGHT = 2'd3;

  function automatic btn_id_t next_id(input btn_id_t id);
    return id + 2'd1;
  endfunction

endpackage

// File: rtl/btn_event_scheduler_if.sv
// Event pop handshake between the scheduler (master) and the game/menu FSM (slave).
interface btn_event_scheduler_if;
  import btn_pkg::*;

  logic    evt_valid;
  btn_id_t evt_id;
  logic    evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);

endinterface

// File: rtl/btn_event_scheduler_debounce.sv
// Two-flop synchronizer plus symmetric counter debounce for one raw button.
// rise pulses for one cycle after the stable level flips 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // this cycle is the DEBOUNCE_CYCLES-th consecutive disagreement
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/btn_event_scheduler.sv
// Debounces four buttons, latches presses as pending requests, and queues them
// round-robin into a small FIFO of button IDs popped via valid/ready.
module btn_event_scheduler
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_BTN-1:0]      btn,
  btn_event_scheduler_if.master   evt,
  output logic [NUM_BTN-1:0]      pending,
  output logic                    overflow
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  logic [NUM_BTN-1:0] rise_vec;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn[g]),
      .rise   (rise_vec[g])
    );
  end

  btn_id_t            mem_q [FIFO_DEPTH];
  btn_id_t            mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]    count_q, count_d;
  btn_id_t            rr_q, rr_d;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic               overflow_q, overflow_d;

  logic               pop, push, push_ok, cand_valid;
  btn_id_t            cand_id, idx;
  logic [NUM_BTN-1:0] gnt_mask;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rr_d       = rr_q;
    cand_valid = 1'b0;
    cand_id    = rr_q;
    idx        = rr_q;
    gnt_mask   = '0;

    pop     = (count_q != '0) && evt.evt_ready;
    push_ok = (count_q < CNTW'(FIFO_DEPTH)) || pop;

    // first pending bit at or above rr, wrapping 3->0
    for (int k = 0; k < NUM_BTN; k++) begin
      idx = rr_q + btn_id_t'(k);
      if (!cand_valid && pending_q[idx]) begin
        cand_valid = 1'b1;
        cand_id    = idx;
      end
    end

    push = cand_valid && push_ok;
    if (push) begin
      gnt_mask[cand_id] = 1'b1;
      mem_d[wr_ptr_q]   = cand_id;
      wr_ptr_d          = wr_ptr_q + PW'(1);
      rr_d              = next_id(cand_id);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNTW'(1);
    end

    // a press arriving on the bit being granted survives as a fresh request
    pending_d  = (pending_q & ~gnt_mask) | rise_vec;
    overflow_d = overflow_q | (|(rise_vec & pending_q & ~gnt_mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_q       <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt.evt_valid = (count_q != '0);
  assign evt.evt_id    = mem_q[rd_ptr_q];
  assign pending       = pending_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed scenarios plus randomized button/ready traffic against a queue-based reference model.
module tb_btn_event_scheduler;
  import btn_pkg::*;

  localparam int DEB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0;
  logic [3:0] pending;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  btn_event_scheduler_if evt_if ();

  btn_event_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .evt     (evt_if),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference model: behaviour of each stage stated directly, FIFO held as a queue.
  bit   m_s1 [4];
  bit   m_s2 [4];
  bit   m_stable [4];
  int   m_run [4];
  bit   m_rise [4];
  bit [3:0] m_pend;
  bit   m_ovf;
  int   m_rr;
  int   m_q [$];
  bit   m_pop, m_pushok, m_g;
  int   m_gid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_run[i] = 0; m_rise[i] = 0;
      end
      m_pend = '0; m_ovf = 0; m_rr = 0;
      m_q.delete();
    end else begin
      m_pop    = (m_q.size() > 0) && (evt_if.evt_ready === 1'b1);
      m_pushok = (m_q.size() < DEPTH) || m_pop;
      m_g = 0; m_gid = 0;
      if (m_pushok)
        for (int k = 0; k < 4; k++)
          if (!m_g && m_pend[(m_rr + k) % 4]) begin m_g = 1; m_gid = (m_rr + k) % 4; end
      if (m_pop) void'(m_q.pop_front());
      if (m_g) begin
        m_q.push_back(m_gid);
        m_pend[m_gid] = 0;
        m_rr = (m_gid + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
        if (m_rise[i]) begin
          if (m_pend[i]) m_ovf = 1;
          m_pend[i] = 1;
        end
      for (int i = 0; i < 4; i++) begin
        m_rise[i] = 0;
        if (m_s2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stable[i] = m_s2[i];
            m_run[i]    = 0;
            m_rise[i]   = m_s2[i];
          end
        end else m_run[i] = 0;
        m_s2[i] = m_s1[i];
        m_s1[i] = btn[i];
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; btn = '0; evt_if.evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input int i);
    btn[i] = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    btn[i] = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = '0; evt_if.evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (evt_if.evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", evt_if.evt_valid); end
    vectors++;
    if (evt_if.evt_id !== 2'd0) begin miscompares++; $display("FAIL reset_id got %0d want 0", evt_if.evt_id); end
    vectors++;
    if (pending !== 4'b0) begin miscompares++; $display("FAIL reset_pending got %b want 0000", pending); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_press();
    do_reset();
    btn[2] = 1'b1;
    for (int e = 0; e <= DEB + 4; e++) begin
      @(posedge clk); #1;
      vectors++;
      if (evt_if.evt_valid !== (e >= DEB + 3)) begin
        miscompares++; $display("FAIL latency_valid edge %0d got %b want %b", e, evt_if.evt_valid, (e >= DEB + 3));
      end
      vectors++;
      if (pending[2] !== (e == DEB + 2)) begin
        miscompares++; $display("FAIL latency_pending edge %0d got %b want %b", e, pending[2], (e == DEB + 2));
      end
      if (e >= DEB + 3) begin
        vectors++;
        if (evt_if.evt_id !== BTN_LEFT) begin miscompares++; $display("FAIL latency_id got %0d want 2", evt_if.evt_id); end
      end
    end
    @(negedge clk); evt_if.evt_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (evt_if.evt_valid !== 1'b0) begin miscompares++; $display("FAIL pop_single got %b want 0", evt_if.evt_valid); end
    @(negedge clk); evt_if.evt_ready = 1'b0; btn[2] = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    vectors++;
    if (evt_if.evt_valid !== 1'b0 || pending !== 4'b0) begin
      miscompares++; $display("FAIL release_no_event got valid=%b pending=%b want 0/0000", evt_if.evt_valid, pending);
    end
  endtask

  task automatic test_glitch();
    bit seen = 0;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      if (c % 5 == 0) btn[0] = ~btn[0];
      @(negedge clk);
      seen |= evt_if.evt_valid;
    end
    btn[0] = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    vectors++;
    if (seen) begin miscompares++; $display("FAIL glitch_event got valid seen want none"); end
    vectors++;
    if (pending !== 4'b0 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL glitch_state got pending=%b ovf=%b want 0000/0", pending, overflow);
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    do_reset();
    evt_if.evt_ready = 1'b1;
    btn = 4'hF;
    while (evt_if.evt_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 40) begin miscompares++; $display("FAIL simul_timeout got no valid want valid within 40 cycles"); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== btn_id_t'(k)) begin
        miscompares++; $display("FAIL simul_order slot %0d got valid=%b id=%0d want 1/%0d", k, evt_if.evt_valid, evt_if.evt_id, k);
      end
      @(negedge clk);
    end
    vectors++;
    if (evt_if.evt_valid !== 1'b0) begin miscompares++; $display("FAIL simul_empty got %b want 0", evt_if.evt_valid); end
    btn = '0; evt_if.evt_ready = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic test_fill_overflow();
    int got [$];
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    vectors++;
    if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd0 || pending !== 4'b0) begin
      miscompares++; $display("FAIL fill_head got valid=%b id=%0d pending=%b want 1/0/0000", evt_if.evt_valid, evt_if.evt_id, pending);
    end
    press(0);
    vectors++;
    if (pending !== 4'b0001 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL fill_wait got pending=%b ovf=%b want 0001/0", pending, overflow);
    end
    press(0);
    vectors++;
    if (pending !== 4'b0001 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL fill_overflow got pending=%b ovf=%b want 0001/1", pending, overflow);
    end
    evt_if.evt_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (evt_if.evt_valid === 1'b1) got.push_back(int'(evt_if.evt_id));
      @(negedge clk);
    end
    evt_if.evt_ready = 1'b0;
    vectors++;
    if (got.size() != 5) begin miscompares++; $display("FAIL drain_count got %0d want 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      vectors++;
      if (got[k] != exp_ids[k]) begin miscompares++; $display("FAIL drain_order slot %0d got %0d want %0d", k, got[k], exp_ids[k]); end
    end
  endtask

  task automatic test_full_pop_push();
    int got [$];
    int exp_ids [4] = '{1, 2, 3, 2};
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    press(2);
    vectors++;
    if (pending !== 4'b0100) begin miscompares++; $display("FAIL full_pending got %b want 0100", pending); end
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
    vectors++;
    if (pending !== 4'b0 || evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd1) begin
      miscompares++; $display("FAIL pop_push got pending=%b valid=%b id=%0d want 0000/1/1", pending, evt_if.evt_valid, evt_if.evt_id);
    end
    evt_if.evt_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (evt_if.evt_valid === 1'b1) got.push_back(int'(evt_if.evt_id));
      @(negedge clk);
    end
    evt_if.evt_ready = 1'b0;
    vectors++;
    if (got.size() != 4) begin miscompares++; $display("FAIL pop_push_count got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      vectors++;
      if (got[k] != exp_ids[k]) begin miscompares++; $display("FAIL pop_push_order slot %0d got %0d want %0d", k, got[k], exp_ids[k]); end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    bit seen = 0;
    do_reset();
    press(0); press(1); press(3);
    btn[2] = 1'b1;
    while (pending[2] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    vectors++;
    if (pending !== 4'b0100 || evt_if.evt_valid !== 1'b1) begin
      miscompares++; $display("FAIL arst_setup got pending=%b valid=%b want 0100/1", pending, evt_if.evt_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (evt_if.evt_valid !== 1'b0 || pending !== 4'b0 || overflow !== 1'b0 || evt_if.evt_id !== 2'd0) begin
      miscompares++; $display("FAIL arst_clear got valid=%b pending=%b ovf=%b id=%0d want 0/0000/0/0",
                              evt_if.evt_valid, pending, overflow, evt_if.evt_id);
    end
    btn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); seen |= evt_if.evt_valid; end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL arst_quiet got event want none"); end
    press(1);
    vectors++;
    if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd1) begin
      miscompares++; $display("FAIL arst_fresh got valid=%b id=%0d want 1/1", evt_if.evt_valid, evt_if.evt_id);
    end
  endtask

  task automatic test_random();
    int hold [4] = '{0, 0, 0, 0};
    int ready_pct = 50;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      vectors++;
      if (evt_if.evt_valid !== (m_q.size() > 0)) begin
        miscompares++; $display("FAIL rand_valid cycle %0d got %b want %b", c, evt_if.evt_valid, (m_q.size() > 0));
      end
      if (m_q.size() > 0) begin
        vectors++;
        if (int'(evt_if.evt_id) != m_q[0]) begin
          miscompares++; $display("FAIL rand_id cycle %0d got %0d want %0d", c, evt_if.evt_id, m_q[0]);
        end
      end
      vectors++;
      if (pending !== m_pend) begin miscompares++; $display("FAIL rand_pending cycle %0d got %b want %b", c, pending, m_pend); end
      vectors++;
      if (overflow !== m_ovf) begin miscompares++; $display("FAIL rand_overflow cycle %0d got %b want %b", c, overflow, m_ovf); end
      if (c % 250 == 0) ready_pct = $urandom_range(0, 3) * 33;
      evt_if.evt_ready = ($urandom_range(0, 99) < ready_pct);
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          btn[i]  = $urandom_range(0, 1);
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(DEB, 3 * DEB);
        end else hold[i]--;
      end
    end
    btn = '0; evt_if.evt_ready = 1'b0;
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_fill_overflow();
    test_full_pop_push();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
